mult_ctrl_m: RTL

Sequencer that drives the 2x2-tile matrix multiplier (the `mult_M` datapath) for a full 5x5 int8 product C = A x B.
- Latches A and B on `start` and walks the 3x3 grid of 2x2 output tiles.
- For each tile, presents two packed rows of A and two packed columns of B, waits the multiplier latency, then scatters the four returned 8-bit results into C.
- Sits between the register/bus front end that holds the operand matrices and the multiplier datapath; reports completion and a sticky overflow flag.

---
 rtl/mult_ctrl_m.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mult_ctrl_m.sv
// mult_ctrl_m: sequencer for the 2x2-tile int8 matrix multiplier (mult_M datapath).
// Computes the 5x5 product C = A x B by walking a 3x3 grid of 2x2 output tiles.
//
// Ports:
//   clk, rst      system clock; asynchronous active-low reset
//   start         begin a run (sampled only while idle)
//   mat_a, mat_b  operand matrices, row-major, element (r,c) at [199-8*(5r+c) -: 8]
//   lin, col      registered operand rows of A / columns of B for the current tile
//   n_in, ovf_in  multiplier result {C(ri,cj),C(ri,cj+1),C(ri+1,cj),C(ri+1,cj+1)} and overflow
//   busy          high from LOAD through the last STORE
//   done          one-cycle completion pulse
//   result        product matrix C, same packing as mat_a
//   ovf_out       sticky overflow over the unpadded tiles of the current run
module mult_ctrl_m #(
  parameter int unsigned LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] mat_a,
  input  logic [199:0] mat_b,
  output logic [79:0]  lin,
  output logic [79:0]  col,
  input  logic [31:0]  n_in,
  input  logic         ovf_in,
  output logic         busy,
  output logic         done,
  output logic [199:0] result,
  output logic         ovf_out
);

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StStore, StDone} state_e;

  state_e        state_q, state_d;
  logic [199:0]  a_q, a_d, b_q, b_d;
  logic [2:0]    ri_q, ri_d, cj_q, cj_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [79:0]   lin_q, lin_d, col_q, col_d;
  logic [199:0]  res_q, res_d;
  logic          ovf_q, ovf_d;

  // Rows r and r+1 of m; row 5 is padding and reads as zero.
  function automatic logic [79:0] pack_rows(input logic [199:0] m, input logic [2:0] r);
    logic [79:0] v;
    v = '0;
    v[79:40] = m[199 - 40*int'(r) -: 40];
    if (r < 3'd4) v[39:0] = m[159 - 40*int'(r) -: 40];
    return v;
  endfunction

  // Columns c and c+1 of m, r0 in the MSB byte; column 5 is padding and reads as zero.
  function automatic logic [79:0] pack_cols(input logic [199:0] m, input logic [2:0] c);
    logic [79:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      v[79 - 8*k -: 8] = m[199 - 8*(5*k + int'(c)) -: 8];
      if (c < 3'd4) v[39 - 8*k -: 8] = m[191 - 8*(5*k + int'(c)) -: 8];
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      ri_q    <= '0;
      cj_q    <= '0;
      cnt_q   <= '0;
      lin_q   <= '0;
      col_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ri_q    <= ri_d;
      cj_q    <= cj_d;
      cnt_q   <= cnt_d;
      lin_q   <= lin_d;
      col_q   <= col_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    int r;
    int c;
    logic [2:0] ri_n;
    logic [2:0] cj_n;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ri_d    = ri_q;
    cj_d    = cj_q;
    cnt_d   = cnt_q;
    lin_d   = lin_q;
    col_d   = col_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    r       = 0;
    c       = 0;
    ri_n    = ri_q;
    cj_n    = cj_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        a_d     = mat_a;
        b_d     = mat_b;
        res_d   = '0;
        ovf_d   = 1'b0;
        ri_d    = '0;
        cj_d    = '0;
        cnt_d   = '0;
        lin_d   = pack_rows(mat_a, 3'd0);
        col_d   = pack_cols(mat_b, 3'd0);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 4'(LAT - 1)) state_d = StStore;
        else cnt_d = cnt_q + 4'd1;
      end
      StStore: begin
        // Scatter the four lanes, dropping any that fall on padding row/column 5.
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            r = int'(ri_q) + i;
            c = int'(cj_q) + j;
            if (r < 5 && c < 5) res_d[199 - 8*(5*r + c) -: 8] = n_in[31 - 8*(2*i + j) -: 8];
          end
        end
        // Tile-level overflow is only trusted when no lane is padding.
        if (ri_q != 3'd4 && cj_q != 3'd4) ovf_d = ovf_q | ovf_in;

        if (cj_q == 3'd4) begin
          cj_n = 3'd0;
          ri_n = ri_q + 3'd2;
        end else begin
          cj_n = cj_q + 3'd2;
        end

        if (ri_q == 3'd4 && cj_q == 3'd4) begin
          state_d = StDone;
        end else begin
          ri_d    = ri_n;
          cj_d    = cj_n;
          cnt_d   = '0;
          lin_d   = pack_rows(a_q, ri_n);
          col_d   = pack_cols(b_q, cj_n);
          state_d = StWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy    = (state_q == StLoad) || (state_q == StWait) || (state_q == StStore);
  assign done    = (state_q == StDone);
  assign lin     = lin_q;
  assign col     = col_q;
  assign result  = res_q;
  assign ovf_out = ovf_q;

endmodule
